read_seq_ctrl: RTL and testbench

- Sequencer for the read_mux datapath.
- Accepts burst read requests and drives the one-hot read word line (rwl) row by row.
- Waits a programmable settle time, then samples the mux output DOUT and returns one bit per row over a valid/ready response channel.
- Sits between the array's read port and any client logic; it is the sole driver of read_mux's rwl input.

---
 rtl/read_seq_pkg.sv | 20 ++
 rtl/rwl_decode.sv | 29 ++
 rtl/read_seq_ctrl.sv | 109 ++++++++++
 tb/tb_read_seq_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/read_seq_pkg.sv
// Shared types and helpers for the read_mux sequencer.
package read_seq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StResp,
        StGap
    } state_e;

    // Widest word-line bus the decoder helper supports.
    localparam int unsigned MaxRows = 64;

    function automatic logic [MaxRows-1:0] onehot_rwl(input int unsigned addr);
        logic [MaxRows-1:0] one;
        one = {{(MaxRows-1){1'b0}}, 1'b1};
        return one << addr;
    endfunction

endpackage

// File: rtl/rwl_decode.sv
// Binary row address to one-hot read word line, forced to zero when disabled.
module rwl_decode
    import read_seq_pkg::*;
#(
    parameter int unsigned ROWS   = 4,
    parameter int unsigned ADDR_W = $clog2(ROWS)
) (
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    output logic [ROWS-1:0]   rwl
);

    logic [MaxRows-1:0] full;

    always_comb begin
        full = '0;
        if (en) begin
            full = onehot_rwl(32'(addr));
        end
    end

    assign rwl = full[ROWS-1:0];

    if (ROWS < MaxRows) begin : g_hi
        logic unused_hi;
        assign unused_hi = ^full[MaxRows-1:ROWS];
    end

endmodule

// File: rtl/read_seq_ctrl.sv
// Burst read sequencer driving read_mux word lines and returning one DOUT bit per row.
// Define RWL_GAP_EN for break-before-make: one all-zero rwl cycle between rows.
module read_seq_ctrl
    import read_seq_pkg::*;
#(
    parameter int unsigned ROWS   = 4,
    parameter int unsigned ADDR_W = $clog2(ROWS),
    parameter int unsigned SETTLE = 1,
    parameter int unsigned CNT_W  = $clog2(SETTLE + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [ADDR_W-1:0] req_len,
    output logic [ROWS-1:0]   rwl,
    input  logic              dout,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_data,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              rsp_last,
    output logic              busy
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(SETTLE - 1);

    state_e            state;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] remain;
    logic [CNT_W-1:0]  cnt;
    logic              rwl_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            cur_addr  <= '0;
            remain    <= '0;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= 1'b0;
            rsp_addr  <= '0;
            rsp_last  <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (req_valid) begin
                        cur_addr <= req_addr;
                        remain   <= req_len;
                        cnt      <= '0;
                        state    <= StDrive;
                    end
                end
                StDrive: begin
                    cnt <= cnt + 1'b1;
                    // DOUT is captured once rwl has been held for SETTLE cycles.
                    if (cnt == CntLast) begin
                        rsp_data  <= dout;
                        rsp_addr  <= cur_addr;
                        rsp_last  <= (remain == '0);
                        rsp_valid <= 1'b1;
                        state     <= StResp;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (rsp_last) begin
                            state <= StIdle;
                        end else begin
                            // ROWS is a power of two, so the increment wraps naturally.
                            cur_addr <= cur_addr + 1'b1;
                            remain   <= remain - 1'b1;
                            cnt      <= '0;
`ifdef RWL_GAP_EN
                            state    <= StGap;
`else
                            state    <= StDrive;
`endif
                        end
                    end
                end
`ifdef RWL_GAP_EN
                StGap: begin
                    state <= StDrive;
                end
`endif
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    assign rwl_en    = (state == StDrive) || (state == StResp);
    assign req_ready = (state == StIdle);
    assign busy      = (state != StIdle);

    rwl_decode #(
        .ROWS   (ROWS),
        .ADDR_W (ADDR_W)
    ) u_rwl_decode (
        .en   (rwl_en),
        .addr (cur_addr),
        .rwl  (rwl)
    );

endmodule

// File: tb/tb_read_seq_ctrl.sv
// Directed bench for read_seq_ctrl: SETTLE=1 and SETTLE=3 instances, read_mux modelled as 4'b1011.
module tb_read_seq_ctrl;

    localparam logic [3:0] MuxIn = 4'b1011;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       a_req_valid, a_req_ready, a_dout, a_rsp_valid, a_rsp_ready;
    logic       a_rsp_data, a_rsp_last, a_busy;
    logic [1:0] a_req_addr, a_req_len, a_rsp_addr;
    logic [3:0] a_rwl;

    logic       b_req_valid, b_req_ready, b_dout, b_rsp_valid, b_rsp_ready;
    logic       b_rsp_data, b_rsp_last, b_busy;
    logic [1:0] b_req_addr, b_req_len, b_rsp_addr;
    logic [3:0] b_rwl;

    assign a_dout = |(a_rwl & MuxIn);
    assign b_dout = |(b_rwl & MuxIn);

    read_seq_ctrl #(.ROWS(4), .SETTLE(1)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .req_valid (a_req_valid),
        .req_ready (a_req_ready),
        .req_addr  (a_req_addr),
        .req_len   (a_req_len),
        .rwl       (a_rwl),
        .dout      (a_dout),
        .rsp_valid (a_rsp_valid),
        .rsp_ready (a_rsp_ready),
        .rsp_data  (a_rsp_data),
        .rsp_addr  (a_rsp_addr),
        .rsp_last  (a_rsp_last),
        .busy      (a_busy)
    );

    read_seq_ctrl #(.ROWS(4), .SETTLE(3)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .req_valid (b_req_valid),
        .req_ready (b_req_ready),
        .req_addr  (b_req_addr),
        .req_len   (b_req_len),
        .rwl       (b_rwl),
        .dout      (b_dout),
        .rsp_valid (b_rsp_valid),
        .rsp_ready (b_rsp_ready),
        .rsp_data  (b_rsp_data),
        .rsp_addr  (b_rsp_addr),
        .rsp_last  (b_rsp_last),
        .busy      (b_busy)
    );

    int checks = 0;
    int errors = 0;

    logic [3:0] exp_rwl [4];
    logic       exp_dat [4];
    logic [1:0] exp_adr [4];

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Burst on dut_a with rsp_ready held high; expectations come from exp_* tables.
    task automatic burst_a(input string tag, input logic [1:0] addr, input logic [1:0] len);
        a_req_addr  = addr;
        a_req_len   = len;
        a_req_valid = 1'b1;
        a_rsp_ready = 1'b1;
        @(negedge clk);
        a_req_valid = 1'b0;
        for (int k = 0; k <= int'(len); k++) begin
            chk({tag, "_drv_rwl"}, a_rwl, exp_rwl[k]);
            chk({tag, "_drv_valid"}, 4'(a_rsp_valid), 4'd0);
            chk({tag, "_drv_onehot"}, 4'($countones(a_rwl) <= 1), 4'd1);
            @(negedge clk);
            chk({tag, "_rsp_rwl"}, a_rwl, exp_rwl[k]);
            chk({tag, "_rsp_valid"}, 4'(a_rsp_valid), 4'd1);
            chk({tag, "_rsp_data"}, 4'(a_rsp_data), 4'(exp_dat[k]));
            chk({tag, "_rsp_addr"}, 4'(a_rsp_addr), 4'(exp_adr[k]));
            chk({tag, "_rsp_last"}, 4'(a_rsp_last), 4'(k == int'(len)));
            @(negedge clk);
`ifdef RWL_GAP_EN
            if (k != int'(len)) begin
                chk({tag, "_gap_rwl"}, a_rwl, 4'b0000);
                chk({tag, "_gap_busy"}, 4'(a_busy), 4'd1);
                @(negedge clk);
            end
`endif
        end
        chk({tag, "_end_rwl"}, a_rwl, 4'b0000);
        chk({tag, "_end_ready"}, 4'(a_req_ready), 4'd1);
    endtask

    initial begin
        rst = 1'b1;
        a_req_valid = 1'b0; a_req_addr = '0; a_req_len = '0; a_rsp_ready = 1'b0;
        b_req_valid = 1'b0; b_req_addr = '0; b_req_len = '0; b_rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rwl", a_rwl, 4'b0000);
        chk("rst_valid", 4'(a_rsp_valid), 4'd0);
        chk("rst_data", 4'(a_rsp_data), 4'd0);
        chk("rst_addr", 4'(a_rsp_addr), 4'd0);
        chk("rst_last", 4'(a_rsp_last), 4'd0);
        chk("rst_busy", 4'(a_busy), 4'd0);
        chk("rst_ready", 4'(a_req_ready), 4'd1);
        chk("rst_b_rwl", b_rwl, 4'b0000);
        rst = 1'b0;
        @(negedge clk);

        // Single read, addr=1 len=0.
        a_req_addr = 2'd1; a_req_len = 2'd0; a_req_valid = 1'b1; a_rsp_ready = 1'b1;
        @(negedge clk);
        a_req_valid = 1'b0;
        chk("s1_drv_rwl", a_rwl, 4'b0010);
        chk("s1_drv_valid", 4'(a_rsp_valid), 4'd0);
        chk("s1_drv_busy", 4'(a_busy), 4'd1);
        chk("s1_drv_ready", 4'(a_req_ready), 4'd0);
        @(negedge clk);
        chk("s1_rsp_rwl", a_rwl, 4'b0010);
        chk("s1_rsp_valid", 4'(a_rsp_valid), 4'd1);
        chk("s1_rsp_data", 4'(a_rsp_data), 4'd1);
        chk("s1_rsp_addr", 4'(a_rsp_addr), 4'd1);
        chk("s1_rsp_last", 4'(a_rsp_last), 4'd1);
        @(negedge clk);
        chk("s1_end_rwl", a_rwl, 4'b0000);
        chk("s1_end_ready", 4'(a_req_ready), 4'd1);
        chk("s1_end_valid", 4'(a_rsp_valid), 4'd0);
        chk("s1_end_busy", 4'(a_busy), 4'd0);

        // Wrap burst addr=2 len=3: rows 2,3,0,1.
        exp_rwl = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};
        exp_dat = '{1'b0, 1'b1, 1'b1, 1'b1};
        exp_adr = '{2'd2, 2'd3, 2'd0, 2'd1};
        burst_a("wrap", 2'd2, 2'd3);

        // Backpressure addr=0 len=1; a competing request during the stall is ignored.
        a_req_addr = 2'd0; a_req_len = 2'd1; a_req_valid = 1'b1; a_rsp_ready = 1'b0;
        @(negedge clk);
        a_req_addr = 2'd3; a_req_len = 2'd0;
        chk("bp_drv_rwl", a_rwl, 4'b0001);
        chk("bp_drv_ready", 4'(a_req_ready), 4'd0);
        @(negedge clk);
        repeat (5) begin
            chk("bp_hold_valid", 4'(a_rsp_valid), 4'd1);
            chk("bp_hold_data", 4'(a_rsp_data), 4'd1);
            chk("bp_hold_addr", 4'(a_rsp_addr), 4'd0);
            chk("bp_hold_last", 4'(a_rsp_last), 4'd0);
            chk("bp_hold_rwl", a_rwl, 4'b0001);
            chk("bp_hold_ready", 4'(a_req_ready), 4'd0);
            @(negedge clk);
        end
        a_req_valid = 1'b0;
        a_rsp_ready = 1'b1;
        @(negedge clk);
`ifdef RWL_GAP_EN
        chk("bp_gap_rwl", a_rwl, 4'b0000);
        @(negedge clk);
`endif
        chk("bp_row1_rwl", a_rwl, 4'b0010);
        chk("bp_row1_valid", 4'(a_rsp_valid), 4'd0);
        @(negedge clk);
        chk("bp_row1_data", 4'(a_rsp_data), 4'd1);
        chk("bp_row1_addr", 4'(a_rsp_addr), 4'd1);
        chk("bp_row1_last", 4'(a_rsp_last), 4'd1);
        @(negedge clk);
        chk("bp_end_rwl", a_rwl, 4'b0000);
        chk("bp_end_ready", 4'(a_req_ready), 4'd1);

        // Two-row burst: gap cycle only when RWL_GAP_EN is defined.
        exp_rwl = '{4'b0001, 4'b0010, 4'b0000, 4'b0000};
        exp_dat = '{1'b1, 1'b1, 1'b0, 1'b0};
        exp_adr = '{2'd0, 2'd1, 2'd0, 2'd0};
        burst_a("gap", 2'd0, 2'd1);

        // SETTLE=3 instance, addr=3 len=0.
        b_req_addr = 2'd3; b_req_len = 2'd0; b_req_valid = 1'b1; b_rsp_ready = 1'b1;
        @(negedge clk);
        b_req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("st3_drv_rwl", b_rwl, 4'b1000);
            chk("st3_drv_valid", 4'(b_rsp_valid), 4'd0);
            @(negedge clk);
        end
        chk("st3_rsp_valid", 4'(b_rsp_valid), 4'd1);
        chk("st3_rsp_data", 4'(b_rsp_data), 4'd1);
        chk("st3_rsp_addr", 4'(b_rsp_addr), 4'd3);
        chk("st3_rsp_last", 4'(b_rsp_last), 4'd1);
        chk("st3_rsp_rwl", b_rwl, 4'b1000);
        @(negedge clk);
        chk("st3_end_rwl", b_rwl, 4'b0000);
        chk("st3_end_busy", 4'(b_busy), 4'd0);

        // Reset while row 3 is driven aborts the burst.
        a_req_addr = 2'd3; a_req_len = 2'd1; a_req_valid = 1'b1; a_rsp_ready = 1'b1;
        @(negedge clk);
        a_req_valid = 1'b0;
        chk("rmid_rwl", a_rwl, 4'b1000);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rmid_after_rwl", a_rwl, 4'b0000);
        chk("rmid_after_valid", 4'(a_rsp_valid), 4'd0);
        chk("rmid_after_busy", 4'(a_busy), 4'd0);
        chk("rmid_after_ready", 4'(a_req_ready), 4'd1);
        exp_rwl = '{4'b0100, 4'b0000, 4'b0000, 4'b0000};
        exp_dat = '{1'b0, 1'b0, 1'b0, 1'b0};
        exp_adr = '{2'd2, 2'd0, 2'd0, 2'd0};
        burst_a("rnew", 2'd2, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
